// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the register-file write port between ALU results and load returns.
// Ports: clk, rst_n (async active-low); alu_valid/alu_ready/alu_rd/alu_data ALU result
// handshake; ld_valid/ld_rd/ld_data load return (always taken); wb_valid/wb_we/wb_sel/
// wb_rd/wb_alu/wb_mem registered writeback stage; fifo_count parked ALU result occupancy.
module wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            wb_valid,
  output logic            wb_we,
  output logic            wb_sel,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_alu,
  output logic [XLEN-1:0] wb_mem,
  output logic [3:0]      fifo_count
);
  logic [4:0]      q_rd [8];
  logic [XLEN-1:0] q_d  [8];
  logic [2:0]      wr_ptr, rd_ptr;
  logic            acc, empty, push, pop;
  assign alu_ready = fifo_count < 4'(DEPTH);
  assign acc       = alu_valid && alu_ready;
  assign empty     = fifo_count == 4'd0;
  // A load always takes the slot, so an ALU result is parked whenever it
  // cannot go straight through: a load is present or older results are waiting.
  assign pop       = !ld_valid && !empty;
  assign push      = acc && (ld_valid || !empty);
  always_ff @(posedge clk)
    if (push) begin
      q_rd[wr_ptr] <= alu_rd;
      q_d[wr_ptr]  <= alu_data;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_sel     <= 1'b0;
      wb_rd      <= '0;
      wb_alu     <= '0;
      wb_mem     <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == 3'(DEPTH - 1)) ? 3'd0 : wr_ptr + 3'd1;
      if (pop) rd_ptr <= (rd_ptr == 3'(DEPTH - 1)) ? 3'd0 : rd_ptr + 3'd1;
      fifo_count <= fifo_count + 4'(push) - 4'(pop);
      if (ld_valid) begin
        wb_valid <= 1'b1;
        wb_we    <= ld_rd != 5'd0;
        wb_sel   <= 1'b1;
        wb_rd    <= ld_rd;
        wb_mem   <= ld_data;
      end else if (!empty) begin
        wb_valid <= 1'b1;
        wb_we    <= q_rd[rd_ptr] != 5'd0;
        wb_sel   <= 1'b0;
        wb_rd    <= q_rd[rd_ptr];
        wb_alu   <= q_d[rd_ptr];
      end else if (acc) begin
        wb_valid <= 1'b1;
        wb_we    <= alu_rd != 5'd0;
        wb_sel   <= 1'b0;
        wb_rd    <= alu_rd;
        wb_alu   <= alu_data;
      end else begin
        wb_valid <= 1'b0;
        wb_we    <= 1'b0;
        wb_sel   <= 1'b0;
      end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: randomized and directed checks of wb_arbiter against a queue-based model.
module tb_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int XLEN  = 32;
  logic            clk = 1'b0, rst_n = 1'b0;
  logic            alu_valid = 1'b0, ld_valid = 1'b0;
  logic [4:0]      alu_rd = '0, ld_rd = '0;
  logic [XLEN-1:0] alu_data = '0, ld_data = '0;
  logic            alu_ready, wb_valid, wb_we, wb_sel;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_alu, wb_mem;
  logic [3:0]      fifo_count;
  int checks = 0, failures = 0;
  typedef struct packed {logic [4:0] rd; logic [XLEN-1:0] d;} ent_t;
  ent_t q[$], acc_log[$], ret_log[$];
  logic            e_valid, e_sel, took;
  logic [4:0]      e_rd;
  logic [XLEN-1:0] e_alu, e_mem;
  wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_sel(wb_sel), .wb_rd(wb_rd),
    .wb_alu(wb_alu), .wb_mem(wb_mem), .fifo_count(fifo_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    acc_log.delete();
    ret_log.delete();
    e_valid = 0; e_sel = 0; e_rd = '0; e_alu = '0; e_mem = '0;
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 64'(wb_valid), 64'(e_valid));
    chk({tag, ".we"}, 64'(wb_we), 64'(e_valid && e_rd != 0));
    chk({tag, ".sel"}, 64'(wb_sel), 64'(e_sel));
    chk({tag, ".rd"}, 64'(wb_rd), 64'(e_rd));
    chk({tag, ".alu"}, 64'(wb_alu), 64'(e_alu));
    chk({tag, ".mem"}, 64'(wb_mem), 64'(e_mem));
    chk({tag, ".count"}, 64'(fifo_count), 64'(q.size()));
    chk({tag, ".ready"}, 64'(alu_ready), 64'(q.size() < DEPTH));
  endtask
  // One clock: the model decides what the writeback stage must hold after the
  // edge from the current inputs, then the DUT is compared just after the edge.
  task automatic step(input string tag);
    ent_t h;
    took = alu_valid && q.size() < DEPTH;
    if (took) acc_log.push_back(ent_t'{alu_rd, alu_data});
    if (ld_valid) begin
      e_valid = 1; e_sel = 1; e_rd = ld_rd; e_mem = ld_data;
      if (took) q.push_back(ent_t'{alu_rd, alu_data});
    end else if (q.size() != 0) begin
      h = q.pop_front();
      e_valid = 1; e_sel = 0; e_rd = h.rd; e_alu = h.d;
      ret_log.push_back(h);
      if (took) q.push_back(ent_t'{alu_rd, alu_data});
    end else if (took) begin
      e_valid = 1; e_sel = 0; e_rd = alu_rd; e_alu = alu_data;
      ret_log.push_back(ent_t'{alu_rd, alu_data});
    end else begin
      e_valid = 0; e_sel = 0;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask
  task automatic drive(input logic av, input logic [4:0] ar, input logic [XLEN-1:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [XLEN-1:0] ldd);
    alu_valid = av; alu_rd = ar; alu_data = ad;
    ld_valid = lv; ld_rd = lr; ld_data = ldd;
  endtask
  initial begin
    int sent, cyc;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
    drive(1, 5'd5, 32'h0000_1234, 0, 0, 0);
    step("bypass");
    chk("bypass.alu_const", 64'(wb_alu), 64'h1234);
    drive(1, 5'd3, 32'hAAAA_0001, 1, 5'd7, 32'hDEAD_BEEF);
    step("coll1");
    chk("coll1.mem_const", 64'(wb_mem), 64'hDEAD_BEEF);
    chk("coll1.cnt_const", 64'(fifo_count), 64'd1);
    drive(0, 0, 0, 0, 0, 0);
    step("coll2");
    chk("coll2.rd_const", 64'(wb_rd), 64'd3);
    chk("coll2.alu_const", 64'(wb_alu), 64'hAAAA_0001);
    drive(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0);
    step("x0alu");
    chk("x0alu.we", 64'(wb_we), 64'd0);
    drive(0, 0, 0, 1, 5'd0, 32'h1111_2222);
    step("x0ld");
    chk("x0ld.we", 64'(wb_we), 64'd0);
    drive(0, 0, 0, 0, 0, 0);
    step("idle");
    chk("idle.hold_alu", 64'(wb_alu), 64'hFFFF_FFFF);
    drive(1, 5'd1, 32'h100, 1, 5'd9, 32'h900);
    step("full1");
    drive(1, 5'd2, 32'h200, 1, 5'd10, 32'hA00);
    step("full2");
    drive(1, 5'd3, 32'h300, 1, 5'd11, 32'hB00);
    chk("full3.ready_before", 64'(alu_ready), 64'd0);
    step("full3");
    drive(1, 5'd3, 32'h300, 0, 0, 0);
    step("drain1");
    chk("drain1.rd", 64'(wb_rd), 64'd1);
    step("drain2");
    chk("drain2.rd", 64'(wb_rd), 64'd2);
    chk("drain2.took3", 64'(took), 64'd1);
    drive(0, 0, 0, 0, 0, 0);
    step("drain3");
    chk("drain3.rd", 64'(wb_rd), 64'd3);
    step("drain4");
    chk("drain4.valid", 64'(wb_valid), 64'd0);
    drive(1, 5'd4, 32'h400, 1, 5'd12, 32'hC00);
    step("pre_rst1");
    drive(1, 5'd6, 32'h600, 1, 5'd13, 32'hD00);
    step("pre_rst2");
    chk("pre_rst.count", 64'(fifo_count), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("midrst");
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all("post_rst");
    sent = 0;
    cyc = 0;
    while (sent < 20 && cyc < 2000) begin
      if (!alu_valid && $urandom_range(0, 1) == 1) begin
        alu_valid = 1'b1;
        alu_rd = 5'($urandom_range(0, 31));
        alu_data = $urandom;
      end
      ld_valid = $urandom_range(0, 99) < 40;
      ld_rd = 5'($urandom_range(0, 31));
      ld_data = $urandom;
      step("rand");
      chk("rand.cnt_le_depth", 64'(fifo_count <= DEPTH), 64'd1);
      if (took) begin
        alu_valid = 1'b0;
        sent++;
      end
      cyc++;
    end
    chk("rand.sent", 64'(sent), 64'd20);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 2; i++) step("flush");
    chk("order.len", 64'(ret_log.size()), 64'(acc_log.size()));
    for (int i = 0; i < acc_log.size() && i < ret_log.size(); i++)
      chk("order.entry", 64'(ret_log[i]), 64'(acc_log[i]));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback-port arbiter for the pipelined RISC-V core. It sequences the single register-file write port between ALU-class results (R, I-arith) and load data returning from data memory. It drives the select of the writeback mux (0 = ALU, 1 = data memory) and registers the destination register and operands feeding it. Load returns cannot be stalled, so they always win the port. Colliding ALU results are parked in a small in-order FIFO and upstream is back-pressured when the FIFO fills.

## Interface
Parameters:
- DEPTH, 2, ALU-result FIFO entries (1..8)
- XLEN, 32, data width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result offered this cycle
- alu_ready  out  1  arbiter can accept ALU result; = (count < DEPTH), depends on state only
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- ld_valid  in  1  load data returning this cycle (no ready; must be taken)
- ld_rd  in  5  load destination register
- ld_data  in  XLEN  load data
- wb_valid  out  1  writeback slot occupied
- wb_we  out  1  register-file write enable; = wb_valid && (wb_rd != 0)
- wb_sel  out  1  writeback mux select: 0 = ALU, 1 = data memory
- wb_rd  out  5  register-file write address
- wb_alu  out  XLEN  to writeback-mux ALU input
- wb_mem  out  XLEN  to writeback-mux data-memory input
- fifo_count  out  4  current FIFO occupancy (debug/perf)

## Operation
- ALU accept: alu_valid && alu_ready at an edge.
- Per-cycle source choice for the writeback register, in priority order:
  1. ld_valid: the load wins. wb_sel=1, wb_rd=ld_rd, wb_mem=ld_data. An accepted ALU result this cycle is pushed to the FIFO.
  2. FIFO non-empty: pop the head. wb_sel=0, wb_rd/wb_alu from the head. An accepted ALU result is pushed at the tail in the same edge.
  3. FIFO empty and ALU accepted: bypass. wb_sel=0, ALU values go straight into the writeback register and nothing is pushed.
  4. Otherwise idle: wb_valid=0 and wb_sel=0. wb_rd, wb_alu and wb_mem hold their previous values.
- Order: ALU results retire strictly in acceptance order. Loads are not ordered against ALU results; the hazard unit guarantees no WAW between a returning load and a buffered ALU result.
- rd = x0: the slot is still consumed (wb_valid=1), but wb_we=0.
- Count update: count += push − pop. Push and pop in the same edge leave count unchanged. The pointers wrap modulo DEPTH.
- Full: alu_ready=0. A pop in the same cycle does not re-enable acceptance until the next cycle.
- Overflow: an ALU offer while alu_ready=0 is ignored. The upstream stage holds it.

## Timing
- Reset (async assert, sync release): wb_valid=0, wb_we=0, wb_sel=0, wb_rd=0, wb_alu=0, wb_mem=0, count=0, pointers=0, alu_ready=1 (DEPTH≥1).
- Reset asserted mid-operation: the FIFO contents are discarded immediately and the outputs go to their reset values in the same cycle.
- Latency: an accepted ALU result or load appears on the wb_* outputs one cycle after the accepting edge (bypass and load cases).
- Buffered ALU results are delayed an extra cycle per load return or older FIFO entry ahead of them.
- Every wb_* output comes from a flop. alu_ready comes from a flop (count), with no combinational path from any input.
- Throughput: one writeback per cycle. A sustained stream of back-to-back loads starves the FIFO indefinitely, which is by design.

## Test plan
- Reset: drive rst_n=0 mid-stream with the FIFO holding 2 entries → all outputs 0 in that cycle, fifo_count=0, alu_ready=1 after release.
- Bypass: ALU rd=5, data=0x0000_1234, no load → next cycle wb_valid=1, wb_we=1, wb_sel=0, wb_rd=5, wb_alu=0x1234, fifo_count=0.
- Collision: same edge ALU rd=3/0xAAAA_0001 and load rd=7/0xDEAD_BEEF →
  - cycle+1: wb_sel=1, wb_rd=7, wb_mem=0xDEADBEEF, fifo_count=1
  - cycle+2: wb_sel=0, wb_rd=3, wb_alu=0xAAAA0001, fifo_count=0
- Full/back-pressure (DEPTH=2): loads on 3 consecutive cycles while ALU offers rd=1,2,3 →
  - rd=1 and rd=2 accepted; alu_ready=0 on the third offer (rd=3 held by upstream)
  - after the loads end: writebacks in order rd=1, rd=2, then rd=3 accepted, no loss or duplication
- x0 handling: ALU rd=0, data=0xFFFF_FFFF → wb_valid=1, wb_we=0 for one cycle. Same check with load rd=0.
- Wrap/ordering: 20 random ALU results interleaved with ~40% load returns → the ALU writeback sequence matches acceptance order exactly, pointers wrap correctly, and fifo_count never exceeds DEPTH.
